// File: rtl/regalumem_mc.sv
// Multi-cycle register file + ALU + word-addressed data memory under a five-state control FSM.
// Optional feature: define REGALUMEM_OVERFLOW_TRAP_EN to trap signed ADD/SUB overflow.
module regalumem_mc #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [2:0]            alu_control,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [15:0]           immediate,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      mem_read_data,
  output logic [WIDTH-1:0]      mem_write_data,
  output logic                  err_overflow,
  output logic                  err_invalid_control,
  output logic                  err_invalid_address
);

  // Handshake: start is sampled only while busy is low; done pulses for the one
  // IDLE cycle after writeback, and start may be asserted in that same cycle.
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [2:0]              ctl_q, ctl_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [15:0]             imm_q, imm_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]        result_q, result_d, mrd_q, mrd_d, mwd_q, mwd_d;
  logic                    eo_q, eo_d, eic_q, eic_d, eia_q, eia_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        rf_q [2**REG_ADDR_W];
  logic [WIDTH-1:0]        rf_d [2**REG_ADDR_W];
  logic [WIDTH-1:0]        mem_q [2**MEM_ADDR_W];

  logic [WIDTH-1:0]        imm_ext, op2, sum, diff, alu_res;
  logic [2:0]              ctl_eff;
  logic                    alu_inv, alu_ovf;
  logic                    addr_ok, mem_we, wb_en;
  logic [MEM_ADDR_W-1:0]   mem_addr;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [WIDTH-1:0]        wb_data;

  assign imm_ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
  assign op2     = (op_q == 2'b00) ? b_q : imm_ext;
  assign ctl_eff = op_q[1] ? ALU_ADD : ctl_q;
  assign sum     = a_q + op2;
  assign diff    = a_q - op2;

  always_comb begin
    alu_res = '0;
    alu_inv = 1'b0;
    case (ctl_eff)
      ALU_AND: alu_res = a_q & op2;
      ALU_OR:  alu_res = a_q | op2;
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(op2))};
      default: alu_inv = 1'b1;
    endcase
  end

`ifdef REGALUMEM_OVERFLOW_TRAP_EN
  logic ovf_add, ovf_sub;
  assign ovf_add = (a_q[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign ovf_sub = (a_q[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
  assign alu_ovf = ((ctl_eff == ALU_ADD) && ovf_add) || ((ctl_eff == ALU_SUB) && ovf_sub);
`else
  assign alu_ovf = 1'b0;
`endif

  // Any set bit at or above MEM_ADDR_W (negative addresses included) is out of range.
  assign addr_ok  = (result_q >> MEM_ADDR_W) == '0;
  assign mem_addr = result_q[MEM_ADDR_W-1:0];
  assign wb_addr  = (op_q == 2'b00) ? rd_q : rt_q;
  assign wb_data  = (op_q == 2'b10) ? mrd_q : result_q;
  assign wb_en    = (op_q != 2'b11) && (wb_addr != '0) && !(eo_q || eic_q || eia_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ctl_d    = ctl_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mrd_d    = mrd_q;
    mwd_d    = mwd_q;
    eo_d     = eo_q;
    eic_d    = eic_q;
    eia_d    = eia_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    rf_d     = rf_q;
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op;
        ctl_d   = alu_control;
        rd_d    = rd;
        rs_d    = rs;
        rt_d    = rt;
        imm_d   = immediate;
        eo_d    = 1'b0;
        eic_d   = 1'b0;
        eia_d   = 1'b0;
        state_d = S_READ;
      end
      S_READ: begin
        a_d     = (rs_q == '0) ? '0 : rf_q[rs_q];
        b_d     = (rt_q == '0) ? '0 : rf_q[rt_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        eo_d     = alu_ovf;
        eic_d    = alu_inv;
        state_d  = op_q[1] ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (!addr_ok) begin
          eia_d = 1'b1;
        end else if (!op_q[0]) begin
          mrd_d = mem_q[mem_addr];
        end else if (!eo_q) begin
          mem_we = 1'b1;
          mwd_d  = b_q;
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (wb_en) rf_d[wb_addr] = wb_data;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      ctl_q    <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mrd_q    <= '0;
      mwd_q    <= '0;
      eo_q     <= 1'b0;
      eic_q    <= 1'b0;
      eia_q    <= 1'b0;
      done_q   <= 1'b0;
      rf_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mrd_q    <= mrd_d;
      mwd_q    <= mwd_d;
      eo_q     <= eo_d;
      eic_q    <= eic_d;
      eia_q    <= eia_d;
      done_q   <= done_d;
      rf_q     <= rf_d;
    end
  end

  // Memory is never cleared; a reset on the MEM edge cancels the pending store.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem_q[mem_addr] <= b_q;
  end

  assign busy                = (state_q != S_IDLE);
  assign done                = done_q;
  assign result              = result_q;
  assign mem_read_data       = mrd_q;
  assign mem_write_data      = mwd_q;
  assign err_overflow        = eo_q;
  assign err_invalid_control = eic_q;
  assign err_invalid_address = eia_q;

endmodule

// File: tb/tb_regalumem_mc.sv
// Directed bench for regalumem_mc: expected result/latency/flags queued at issue, checked at done.
module tb_regalumem_mc;
  localparam int W = 32;
`ifdef REGALUMEM_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [2:0]    alu_control = '0;
  logic [4:0]    rd = '0, rs = '0, rt = '0;
  logic [15:0]   immediate = '0;
  logic          busy, done;
  logic [W-1:0]  result, mem_read_data, mem_write_data;
  logic          err_overflow, err_invalid_control, err_invalid_address;

  logic [W-1:0]  exp_q[$];
  int            lat_q[$];
  logic [2:0]    err_q[$];
  int            n_vec = 0;
  int            n_miss = 0;

  regalumem_mc #(.WIDTH(W), .REG_ADDR_W(5), .MEM_ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .alu_control(alu_control),
    .rd(rd), .rs(rs), .rt(rt), .immediate(immediate), .busy(busy), .done(done),
    .result(result), .mem_read_data(mem_read_data), .mem_write_data(mem_write_data),
    .err_overflow(err_overflow), .err_invalid_control(err_invalid_control),
    .err_invalid_address(err_invalid_address)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op; inputs are driven in the current cycle (back-to-back with a prior done).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] c,
                        input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                        input logic [15:0] im, input logic [W-1:0] er, input int el,
                        input logic [2:0] ee);
    int cnt;
    exp_q.push_back(er);
    lat_q.push_back(el);
    err_q.push_back(ee);
    op = o; alu_control = c; rd = d; rs = s; rt = t; immediate = im; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 12) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk({tag, ".done"}, {63'd0, done}, 64'd1);
    chk({tag, ".lat"}, 64'(cnt), 64'(lat_q.pop_front()));
    chk({tag, ".result"}, 64'(result), 64'(exp_q.pop_front()));
    chk({tag, ".err"}, {61'd0, err_overflow, err_invalid_control, err_invalid_address},
        {61'd0, err_q.pop_front()});
  endtask

  task automatic read_reg(input string tag, input logic [4:0] r, input logic [W-1:0] ev);
    run_op(tag, 2'b00, 3'b001, 5'd0, r, 5'd0, 16'h0, ev, 3, 3'b000);
  endtask

  initial begin
    logic [W-1:0] v;
    int cnt;
    logic seen_done;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset.ctl", {62'd0, busy, done}, 64'd0);
    chk("reset.data", {result, mem_read_data | mem_write_data}, 64'd0);
    chk("reset.err", {61'd0, err_overflow, err_invalid_control, err_invalid_address}, 64'd0);
    read_reg("reset.r1", 5'd1, '0);

    run_op("addi.r1", 2'b01, 3'b010, 5'd0, 5'd0, 5'd1, 16'd10, 32'd10, 3, 3'b000);
    run_op("addi.r2", 2'b01, 3'b010, 5'd0, 5'd0, 5'd2, 16'd32, 32'd32, 3, 3'b000);
    run_op("add.r3", 2'b00, 3'b010, 5'd3, 5'd1, 5'd2, 16'h0, 32'd42, 3, 3'b000);
    read_reg("rd.r3", 5'd3, 32'd42);
    run_op("subi.r4", 2'b01, 3'b110, 5'd0, 5'd3, 5'd4, 16'hFFFF, 32'd43, 3, 3'b000);
    read_reg("rd.r4", 5'd4, 32'd43);
    run_op("addi.r5", 2'b01, 3'b010, 5'd0, 5'd0, 5'd5, 16'd5, 32'd5, 3, 3'b000);
    run_op("slti.neg", 2'b01, 3'b111, 5'd0, 5'd5, 5'd6, 16'hFFFF, 32'd0, 3, 3'b000);
    run_op("slti.pos", 2'b01, 3'b111, 5'd0, 5'd5, 5'd7, 16'd7, 32'd1, 3, 3'b000);
    run_op("addi.r8", 2'b01, 3'b010, 5'd0, 5'd0, 5'd8, 16'h7878, 32'h7878, 3, 3'b000);
    run_op("dbl.r8", 2'b00, 3'b010, 5'd8, 5'd8, 5'd8, 16'h0, 32'hF0F0, 3, 3'b000);
    run_op("ori.r9", 2'b01, 3'b001, 5'd0, 5'd0, 5'd9, 16'h0FF0, 32'h0FF0, 3, 3'b000);
    run_op("and.r10", 2'b00, 3'b000, 5'd10, 5'd8, 5'd9, 16'h0, 32'h00F0, 3, 3'b000);
    run_op("or.r11", 2'b00, 3'b001, 5'd11, 5'd8, 5'd9, 16'h0, 32'hFFF0, 3, 3'b000);
    read_reg("rd.r10", 5'd10, 32'h00F0);

    run_op("store7", 2'b11, 3'b000, 5'd0, 5'd0, 5'd4, 16'd7, 32'd7, 4, 3'b000);
    chk("store7.mwd", 64'(mem_write_data), 64'd43);
    run_op("load7", 2'b10, 3'b000, 5'd0, 5'd0, 5'd5, 16'd7, 32'd7, 4, 3'b000);
    chk("load7.mrd", 64'(mem_read_data), 64'd43);
    read_reg("rd.r5", 5'd5, 32'd43);

    run_op("load256.r0", 2'b10, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0100, 32'd256, 4, 3'b001);
    chk("load256.mrd", 64'(mem_read_data), 64'd43);
    run_op("load256.r12", 2'b10, 3'b000, 5'd0, 5'd0, 5'd12, 16'h0100, 32'd256, 4, 3'b001);
    read_reg("rd.r12", 5'd12, '0);
    run_op("loadneg", 2'b10, 3'b000, 5'd0, 5'd0, 5'd12, 16'hFFFF, 32'hFFFF_FFFF, 4, 3'b001);
    run_op("addi.r0", 2'b01, 3'b010, 5'd0, 5'd0, 5'd0, 16'd5, 32'd5, 3, 3'b000);
    read_reg("rd.r0", 5'd0, '0);

    // Build 0x7FFFFFFF without ever overflowing.
    run_op("addi.r13", 2'b01, 3'b010, 5'd0, 5'd0, 5'd13, 16'h4000, 32'h4000, 3, 3'b000);
    v = 32'h4000;
    for (int i = 0; i < 16; i++) begin
      v = v << 1;
      run_op("dbl.r13", 2'b00, 3'b010, 5'd13, 5'd13, 5'd13, 16'h0, v, 3, 3'b000);
    end
    run_op("addi.r14", 2'b01, 3'b010, 5'd0, 5'd13, 5'd14, 16'hFFFF, 32'h3FFF_FFFF, 3, 3'b000);
    run_op("add.r15", 2'b00, 3'b010, 5'd15, 5'd13, 5'd14, 16'h0, 32'h7FFF_FFFF, 3, 3'b000);
    run_op("ovf.r16", 2'b01, 3'b010, 5'd0, 5'd15, 5'd16, 16'd1, 32'h8000_0000, 3,
           TRAP ? 3'b100 : 3'b000);
    read_reg("rd.r16", 5'd16, TRAP ? 32'h0 : 32'h8000_0000);

    exp_q.push_back(32'd0);
    op = 2'b00; alu_control = 3'b011; rd = 5'd17; rs = 5'd1; rt = 5'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cnt = 0;
    while (!done && cnt < 12) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk("inv.lat", 64'(cnt), 64'd3);
    chk("inv.flag", {63'd0, err_invalid_control}, 64'd1);
    read_reg("rd.r17", 5'd17, exp_q.pop_front());

    // start held high with different fields while busy must be ignored.
    op = 2'b01; alu_control = 3'b010; rs = 5'd0; rt = 5'd18; immediate = 16'd3; start = 1'b1;
    @(posedge clock); #1;
    rt = 5'd19; immediate = 16'd99;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("busy.wb", {63'd0, busy}, 64'd1);
    start = 1'b0;
    @(posedge clock); #1;
    chk("busy.done", {63'd0, done}, 64'd1);
    chk("busy.result", 64'(result), 64'd3);
    read_reg("rd.r18", 5'd18, 32'd3);
    read_reg("rd.r19", 5'd19, '0);
    @(posedge clock); #1;
    chk("done.pulse", {63'd0, done}, 64'd0);

    run_op("store9", 2'b11, 3'b000, 5'd0, 5'd0, 5'd3, 16'd9, 32'd9, 4, 3'b000);
    chk("store9.mwd", 64'(mem_write_data), 64'd42);
    op = 2'b11; alu_control = 3'b000; rs = 5'd0; rt = 5'd1; immediate = 16'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort.ctl", {62'd0, busy, done}, 64'd0);
    chk("abort.data", {result, mem_read_data | mem_write_data}, 64'd0);
    chk("abort.err", {61'd0, err_overflow, err_invalid_control, err_invalid_address}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      seen_done = seen_done | done;
    end
    chk("abort.nodone", {63'd0, seen_done}, 64'd0);
    run_op("load9", 2'b10, 3'b000, 5'd0, 5'd0, 5'd20, 16'd9, 32'd9, 4, 3'b000);
    chk("load9.mrd", 64'(mem_read_data), 64'd42);
    read_reg("rd.r3.cleared", 5'd3, '0);
    read_reg("rd.r20", 5'd20, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/regalumem_mc.md
# regalumem_mc

Parametrised multi-cycle execution unit combining a register file, ALU and word-addressed data memory under one control FSM. Accepts one operation per start pulse, reads two source registers, executes an ALU, load or store operation and writes back, signalling completion with a one-cycle done pulse. Sits between the instruction decoder and the rest of the MIPS datapath, and is the sequenced, width- and depth-generic successor of the flat register/ALU/memory composition.

## Interface
- WIDTH, 32, datapath and register width in bits (≥16)
- REG_ADDR_W, 5, register address width; 2^REG_ADDR_W registers, register 0 reads as zero
- MEM_ADDR_W, 8, data memory word-address width; depth 2^MEM_ADDR_W words
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue request, sampled only in IDLE
- op  in  2  00 R-type ALU, 01 ALU-immediate, 10 load, 11 store
- alu_control  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others invalid
- rd, rs, rt  in  REG_ADDR_W each  destination, source A, source B / store-data register
- immediate  in  16  sign-extended to WIDTH
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  latched ALU result / effective address
- mem_read_data  out  WIDTH  latched load data
- mem_write_data  out  WIDTH  latched store data
- err_overflow  out  1  signed ADD/SUB overflow of last op
- err_invalid_control  out  1  unsupported alu_control in last op
- err_invalid_address  out  1  load/store effective address ≥ 2^MEM_ADDR_W

## Operation
- States: IDLE, READ, EXEC, MEM, WB; one transition per edge.
- IDLE: start=1 latches op, alu_control, rd, rs, rt, immediate; → READ. start ignored outside IDLE.
- READ: latch A=reg[rs], B=reg[rt] (reg 0 yields 0); → EXEC.
- EXEC: operand2 = B for op 00, sext(immediate) otherwise. Loads/stores force ADD. Latch result, error flags; → MEM for op 1x, else → WB.
- MEM: effective address = result. In range: load latches mem[result] into mem_read_data; store writes B to mem[result] and latches B into mem_write_data. Out of range (any bit at or above MEM_ADDR_W set, including negative): no access, err_invalid_address=1. → WB.
- WB: op 00 writes result to rd; op 01 and load write to rt (load writes mem_read_data). Write suppressed when target is 0, or any error flag set. Store never writes. → IDLE, done=1 for one cycle.
- Arithmetic modulo 2^WIDTH; SLT is signed, result 1 or 0; SUB is A−operand2.
- Error flags cleared on each accepted start, hold until next start.

## Timing
- Reset: state IDLE, busy=0, done=0, result=0, mem_read_data=0, mem_write_data=0, all err flags 0, all registers cleared to 0; memory contents retained.
- Start sampled at edge E0. ALU ops: done high in the cycle after E3 (latency 3 edges). Load/store: done after E4 (latency 4).
- Back-to-back: start asserted while done=1 (state IDLE) is accepted; the new op's READ sees the just-written register.
- Reset mid-operation: abort at that edge, no pending register or memory write occurs, done not pulsed.
- result, mem_read_data, mem_write_data change only at the EXEC/MEM edges that produce them.

## Configuration
- REGALUMEM_OVERFLOW_TRAP_EN defined: signed overflow on ADD/SUB (including address calc) sets err_overflow and suppresses writeback and memory write.
- Undefined: err_overflow tied 0; results wrap and are written normally.

## Test plan
- Reset, then R-type ADD rs=1 (10), rt=2 (32) → rd=3: done 3 edges after start, reg3=42, result=42, no errors.
- ALU-immediate SUB rs=3 (42), imm=0xFFFF → rt=4: reg4=43; SLT 5 vs −1 → 0; AND/OR of 0xF0F0/0x0FF0 → 0x00F0/0xFFF0.
- Store reg4 (43) to addr rs=0 + imm=7, then load addr 7 → rt=5: store done after 4 edges, mem_write_data=43; reg5=43, mem_read_data=43.
- Load from addr 256 (MEM_ADDR_W=8) and write to rd=0: err_invalid_address=1, target unchanged; reg0 reads 0 after any write attempt.
- ADD 0x7FFFFFFF+1: with REGALUMEM_OVERFLOW_TRAP_EN err_overflow=1 and rd unchanged; without, rd=0x80000000, err_overflow=0. alu_control=011 → err_invalid_control=1, no write.
- Reset asserted in MEM of a store: memory word unchanged, done never pulses, all outputs zero next cycle; start during busy ignored.
